vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 115 +++++++++++
 tb/tb_vga_timing_gen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: sync, data-enable and pixel position decoded from free-running h/v counters,
// plus a fetch request running READ_DELAY clocks ahead of de_o so pixel memory data lines up with it.
module vga_timing_gen #(
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   H_DISP     = 640,
    parameter int   H_FP       = 16,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter int   V_DISP     = 480,
    parameter int   V_FP       = 10,
    parameter int   READ_DELAY = 2,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   FCNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_i,
    output logic                       h_sync_o,
    output logic                       v_sync_o,
    output logic                       de_o,
    output logic [$clog2(H_DISP)-1:0]  pos_x_o,
    output logic [$clog2(V_DISP)-1:0]  pos_y_o,
    output logic                       req_o,
    output logic [$clog2(H_DISP)-1:0]  req_x_o,
    output logic [$clog2(V_DISP)-1:0]  req_y_o,
    output logic                       line_start_o,
    output logic                       frame_start_o,
    output logic [FCNT_W-1:0]          frame_cnt_o
);

    localparam int H_START = H_SYNC + H_BP;
    localparam int H_END   = H_START + H_DISP;
    localparam int H_TOTAL = H_END + H_FP;
    localparam int V_START = V_SYNC + V_BP;
    localparam int V_END   = V_START + V_DISP;
    localparam int V_TOTAL = V_END + V_FP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int XW      = $clog2(H_DISP);
    localparam int YW      = $clog2(V_DISP);

    // One spare bit so h_cnt + READ_DELAY and the end-of-region bounds never wrap.
    typedef logic [HW:0]   hx_t;
    typedef logic [VW:0]   vx_t;
    typedef logic [XW-1:0] x_t;
    typedef logic [YW-1:0] y_t;

    localparam hx_t H_SYNC_E  = hx_t'(H_SYNC);
    localparam hx_t H_START_E = hx_t'(H_START);
    localparam hx_t H_END_E   = hx_t'(H_END);
    localparam hx_t H_LAST_E  = hx_t'(H_TOTAL - 1);
    localparam hx_t RD_E      = hx_t'(READ_DELAY);
    localparam vx_t V_SYNC_E  = vx_t'(V_SYNC);
    localparam vx_t V_START_E = vx_t'(V_START);
    localparam vx_t V_END_E   = vx_t'(V_END);
    localparam vx_t V_LAST_E  = vx_t'(V_TOTAL - 1);

    generate
        if (READ_DELAY < 0 || READ_DELAY > H_START) begin : g_bad_read_delay
            $error("READ_DELAY must lie in 0..H_SYNC+H_BP");
        end
    endgenerate

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    hx_t           h_ext;
    hx_t           h_req;
    vx_t           v_ext;
    logic          h_last;
    logic          v_last;
    logic          v_act;

    assign h_ext  = {1'b0, h_cnt};
    assign v_ext  = {1'b0, v_cnt};
    assign h_req  = h_ext + RD_E;
    assign h_last = (h_ext == H_LAST_E);
    assign v_last = (v_ext == V_LAST_E);
    assign v_act  = (v_ext >= V_START_E) && (v_ext < V_END_E);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_cnt_o <= '0;
        end else if (!en_i) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_last ? '0 : h_cnt + 1'b1;
            if (h_last) begin
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
                if (v_last) begin
                    frame_cnt_o <= frame_cnt_o + 1'b1;
                end
            end
        end
    end

    assign h_sync_o = (h_ext < H_SYNC_E) ? SYNC_POL : ~SYNC_POL;
    assign v_sync_o = (v_ext < V_SYNC_E) ? SYNC_POL : ~SYNC_POL;

    assign de_o    = v_act && (h_ext >= H_START_E) && (h_ext < H_END_E);
    assign pos_x_o = de_o ? x_t'(h_ext - H_START_E) : '0;
    assign pos_y_o = de_o ? y_t'(v_ext - V_START_E) : '0;

    // Same window as de_o, evaluated on the look-ahead column; it closes READ_DELAY early so it never crosses a line.
    assign req_o   = v_act && (h_req >= H_START_E) && (h_req < H_END_E);
    assign req_x_o = req_o ? x_t'(h_req - H_START_E) : '0;
    assign req_y_o = req_o ? y_t'(v_ext - V_START_E) : '0;

    assign line_start_o  = en_i && (h_cnt == '0);
    assign frame_start_o = line_start_o && (v_cnt == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three small-raster instances in lockstep, checked against a raster-position model.
module tb_vga_timing_gen;

    localparam int HT = 14;          // 2 sync + 3 bp + 8 active + 1 fp
    localparam int VT = 7;           // 1 sync + 1 bp + 4 active + 1 fp
    localparam int FT = HT * VT;

    logic clk = 1'b0;
    logic rst;
    logic en;

    logic       hs_a, vs_a, de_a, rq_a, ls_a, fs_a;
    logic [2:0] px_a, rx_a;
    logic [1:0] py_a, ry_a;
    logic [15:0] fc_a;
    logic       hs_b, vs_b, de_b, rq_b, ls_b, fs_b;
    logic [2:0] px_b, rx_b;
    logic [1:0] py_b, ry_b;
    logic [1:0] fc_b;
    logic       hs_c, vs_c, de_c, rq_c, ls_c, fs_c;
    logic [2:0] px_c, rx_c;
    logic [1:0] py_c, ry_c;
    logic [15:0] fc_c;

    int t;        // enabled clocks since the raster last restarted
    int frames;   // completed frames since reset
    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(.H_SYNC(2), .H_BP(3), .H_DISP(8), .H_FP(1), .V_SYNC(1), .V_BP(1), .V_DISP(4), .V_FP(1),
                     .READ_DELAY(2), .SYNC_POL(1'b0), .FCNT_W(16)) u_a (
        .clk(clk), .rst(rst), .en_i(en), .h_sync_o(hs_a), .v_sync_o(vs_a), .de_o(de_a),
        .pos_x_o(px_a), .pos_y_o(py_a), .req_o(rq_a), .req_x_o(rx_a), .req_y_o(ry_a),
        .line_start_o(ls_a), .frame_start_o(fs_a), .frame_cnt_o(fc_a));

    vga_timing_gen #(.H_SYNC(2), .H_BP(3), .H_DISP(8), .H_FP(1), .V_SYNC(1), .V_BP(1), .V_DISP(4), .V_FP(1),
                     .READ_DELAY(0), .SYNC_POL(1'b1), .FCNT_W(2)) u_b (
        .clk(clk), .rst(rst), .en_i(en), .h_sync_o(hs_b), .v_sync_o(vs_b), .de_o(de_b),
        .pos_x_o(px_b), .pos_y_o(py_b), .req_o(rq_b), .req_x_o(rx_b), .req_y_o(ry_b),
        .line_start_o(ls_b), .frame_start_o(fs_b), .frame_cnt_o(fc_b));

    vga_timing_gen #(.H_SYNC(2), .H_BP(3), .H_DISP(8), .H_FP(1), .V_SYNC(1), .V_BP(1), .V_DISP(4), .V_FP(1),
                     .READ_DELAY(5), .SYNC_POL(1'b0), .FCNT_W(16)) u_c (
        .clk(clk), .rst(rst), .en_i(en), .h_sync_o(hs_c), .v_sync_o(vs_c), .de_o(de_c),
        .pos_x_o(px_c), .pos_y_o(py_c), .req_o(rq_c), .req_x_o(rx_c), .req_y_o(ry_c),
        .line_start_o(ls_c), .frame_start_o(fs_c), .frame_cnt_o(fc_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at t=%0d: got %0d, expected %0d", tag, t, got, exp);
        end
    endtask

    // Expected outputs follow from where position t lands in the raster.
    task automatic chk_inst(input string n, input int rd, input int pol, input int fw,
                            input logic hs, input logic vs, input logic de,
                            input logic [2:0] px, input logic [1:0] py,
                            input logic rq, input logic [2:0] rx, input logic [1:0] ry,
                            input logic ls, input logic fs, input logic [15:0] fc);
        int h, v, hr;
        bit row, xde, xrq;
        h   = t % HT;
        v   = (t / HT) % VT;
        hr  = h + rd;
        row = (v >= 2) && (v < 6);
        xde = row && (h >= 5) && (h < 13);
        xrq = row && (hr >= 5) && (hr < 13);
        chk({n, ".h_sync"}, 32'(hs), (h < 2) ? pol : 1 - pol);
        chk({n, ".v_sync"}, 32'(vs), (v < 1) ? pol : 1 - pol);
        chk({n, ".de"},     32'(de), xde ? 1 : 0);
        chk({n, ".pos_x"},  32'(px), xde ? h - 5 : 0);
        chk({n, ".pos_y"},  32'(py), xde ? v - 2 : 0);
        chk({n, ".req"},    32'(rq), xrq ? 1 : 0);
        chk({n, ".req_x"},  32'(rx), xrq ? hr - 5 : 0);
        chk({n, ".req_y"},  32'(ry), xrq ? v - 2 : 0);
        chk({n, ".line_start"},  32'(ls), (en && h == 0) ? 1 : 0);
        chk({n, ".frame_start"}, 32'(fs), (en && h == 0 && v == 0) ? 1 : 0);
        chk({n, ".frame_cnt"},   32'(fc), frames % (1 << fw));
    endtask

    task automatic check_all();
        chk_inst("a", 2, 0, 16, hs_a, vs_a, de_a, px_a, py_a, rq_a, rx_a, ry_a, ls_a, fs_a, fc_a);
        chk_inst("b", 0, 1, 2,  hs_b, vs_b, de_b, px_b, py_b, rq_b, rx_b, ry_b, ls_b, fs_b, 16'(fc_b));
        chk_inst("c", 5, 0, 16, hs_c, vs_c, de_c, px_c, py_c, rq_c, rx_c, ry_c, ls_c, fs_c, fc_c);
    endtask

    task automatic tick();
        @(posedge clk);
        if (en) begin
            if (t % FT == FT - 1) frames++;
            t++;
        end else begin
            t = 0;
        end
        @(negedge clk);
        check_all();
    endtask

    // Called just after a falling edge: the pulse sits well clear of both clock edges.
    task automatic pulse_reset();
        #2 rst = 1'b1;
        t = 0;
        frames = 0;
        #1 check_all();
        chk("rst.frame_cnt_a", 32'(fc_a), 0);
        rst = 1'b0;
    endtask

    initial begin
        int first_de, last_de, prev_fs, keep_frames;
        rst = 1'b1;
        en = 1'b1;
        t = 0;
        frames = 0;
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        first_de = -1;
        last_de  = -1;
        prev_fs  = 0;
        for (int i = 0; i < 4 * FT; i++) begin
            tick();
            if (de_a && first_de < 0) first_de = t;
            if (de_a && px_a == 3'd7 && py_a == 2'd3 && last_de < 0) last_de = t;
            if (fs_a) begin
                chk("frame_start.period", t - prev_fs, FT);
                prev_fs = t;
            end
            if (t == 2 * HT) chk("c.req_x0_at_h0", 32'({rq_c, rx_c}), 32'h8);
            if (t == 3 * FT) begin
                chk("a.frame_cnt@294", 32'(fc_a), 3);
                chk("b.frame_cnt@294", 32'(fc_b), 3);
            end
        end
        chk("first_de_clock", first_de, 33);
        chk("last_de_clock", last_de, 5 * HT + 12);   // row 3 sits on line 5, last pixel at h=12
        chk("b.frame_cnt_wrap", 32'(fc_b), 0);

        for (int i = 0; i < FT && (t % FT) != 3 * HT + 7; i++) tick();
        chk("gate.position", t % FT, 3 * HT + 7);
        keep_frames = frames;
        en = 1'b0;
        #1 check_all();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("gate.de", 32'(de_a), 0);
            chk("gate.frame_cnt_hold", 32'(fc_a), keep_frames);
        end
        en = 1'b1;
        #1 check_all();
        chk("gate.frame_start_on_restore", 32'(fs_a), 1);
        for (int i = 0; i < HT; i++) tick();

        for (int i = 0; i < HT && (t % HT) != 6; i++) tick();
        pulse_reset();
        for (int i = 0; i < 2 * HT; i++) tick();

        for (int i = 0; i < 1500; i++) begin
            en = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 299) == 0) pulse_reset();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
